frame_uart_tx: RTL
==================

Name: frame_uart_tx

Overview:
Streams a stored 24-bit RGB frame back to the host over UART, in the opposite direction to the UART RX pixel path. On a start pulse it reads pixels 0..NUM_PIXELS-1 from frame memory and splits each pixel into three bytes, R then G then B. Bytes are serialized 8N1, LSB first, using an internal baud divider and shifter. It sits between the frame buffer read port and the board TX pin.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz
BAUD_RATE, 115200, UART bit rate
NUM_PIXELS, 40800, pixels per frame
ADDR_W, 16, frame memory address width
BAUD_DIV (localparam), CLK_FREQ/BAUD_RATE truncated, clock cycles per bit

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  request frame transmission; sampled only when busy=0
mem_rd_en  output  1  frame memory read strobe
mem_addr  output  ADDR_W  frame memory read address
mem_rdata  input  24  pixel data {R[23:16],G[15:8],B[7:0]}, valid 1 cycle after mem_rd_en
tx  output  1  UART serial out, idle high
busy  output  1  frame in progress
pixel_cnt  output  ADDR_W  index of the pixel currently being sent
frame_done  output  1  one-cycle pulse after the last stop bit of the frame

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high. All state is cleared on the clk edge where reset=1.
- Reset values: tx=1, busy=0, frame_done=0, mem_rd_en=0, mem_addr=0, pixel_cnt=0, FSM=IDLE, baud counter=0.
- IDLE
  - start=1 -> FETCH, busy=1, pixel_cnt=0.
  - start=0 -> stay in IDLE.
- FETCH
  - mem_rd_en=1 for exactly 1 cycle, mem_addr=pixel_cnt -> WAIT.
- WAIT
  - Latch mem_rdata into a 24-bit pixel register, byte_idx=0 -> SEND.
- SEND
  - Serialize byte_idx 0=R, 1=G, 2=B.
  - The start bit of byte 0 begins the cycle after WAIT.
  - Each bit holds tx for exactly BAUD_DIV cycles: start bit (0), d0..d7, stop bit (1). 10 bit periods per byte.
  - The baud counter restarts at each byte's start bit, so no partial first bit.
  - Inside a pixel, byte n+1's start bit begins the cycle after byte n's stop period ends (zero idle gap).
  - After byte 2's stop bit -> NEXT.
- NEXT
  - If pixel_cnt==NUM_PIXELS-1 -> DONE.
  - Otherwise pixel_cnt+1 -> FETCH.
  - This gives exactly 3 idle-high cycles between pixels (NEXT, FETCH, WAIT).
- DONE
  - frame_done=1 for 1 cycle, busy stays 1 -> IDLE.
  - In IDLE: busy=0, pixel_cnt holds NUM_PIXELS-1.
- start while busy=1 (including the DONE cycle): ignored, not queued.
- mem_addr holds its last value outside FETCH. mem_rdata is ignored except in WAIT.
- Reset mid-frame or mid-byte: the truncated byte is abandoned. tx=1 from the next cycle, and all outputs return to reset values. The next start begins again at address 0.
- pixel_cnt never exceeds NUM_PIXELS-1, and no address is issued beyond it.
- Frame duration from start accepted to frame_done: NUM_PIXELS*(30*BAUD_DIV+3)+2 cycles.

Test Plan:
- Reset check: assert reset 3 cycles with start=1 -> tx=1, busy=0, frame_done=0, mem_rd_en=0, pixel_cnt=0 throughout; nothing transmitted.
- Basic frame (CLK_FREQ=1_000_000, BAUD_RATE=100_000 so BAUD_DIV=10; NUM_PIXELS=2; mem[0]=0xA1B2C3, mem[1]=0x00FF80), 1-cycle start pulse:
  - mem_rd_en at addresses 0 then 1.
  - UART monitor decodes bytes A1,B2,C3,00,FF,80, each bit exactly 10 cycles, LSB first.
  - 3 idle-high cycles between C3 and 00.
  - frame_done pulses once, 1 cycle after the final stop bit.
  - busy=0 the following cycle.
- Start while busy (same config): extra start pulses during byte B2 and during the DONE cycle -> still exactly 6 bytes and one frame_done; tx idle afterwards.
- Reset mid-byte: reset asserted at bit d3 of byte G of pixel 0 -> tx=1 and busy=0 next cycle. A new start resends from 0xA1 with correct timing.
- Continuous start held high, NUM_PIXELS=2 -> frames repeat. Each frame has 1 IDLE cycle after DONE and pixel_cnt restarts at 0. Two full frames yield 12 correct bytes and 2 frame_done pulses.
- Data sweep, NUM_PIXELS=4, pixels 0x000000, 0xFFFFFF, 0x555555, 0xAAAAAA -> decoded bytes match; total frame length is 4*(300+3)+2=1214 cycles from start to frame_done.

Source files
------------

// File: rtl/frame_uart_tx.sv
// frame_uart_tx: reads a stored RGB frame pixel by pixel and sends each pixel as R, G, B bytes over 8N1 UART.
module frame_uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int NUM_PIXELS = 40800,
  parameter int ADDR_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic              tx,
  output logic              busy,
  output logic [ADDR_W-1:0] pixel_cnt,
  output logic              frame_done
);
  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, NEXT, DONE} state_t;
  state_t            state_q;
  logic [CW-1:0]     baud_q;
  logic [3:0]        bit_q;
  logic [1:0]        byte_q;
  logic [8:0]        sh_q;
  logic [15:0]       pix_q;
  logic              rd_en_q, tx_q, busy_q, done_q;
  logic [ADDR_W-1:0] addr_q, cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      sh_q    <= '1;
      pix_q   <= '0;
      rd_en_q <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= FETCH;
          busy_q  <= 1'b1;
          cnt_q   <= '0;
          addr_q  <= '0;
          rd_en_q <= 1'b1;
        end
        FETCH: state_q <= WAIT;
        WAIT: begin
          // sh_q holds the data bits with the stop bit parked above them
          sh_q    <= {1'b1, mem_rdata[23:16]};
          pix_q   <= mem_rdata[15:0];
          byte_q  <= '0;
          bit_q   <= '0;
          baud_q  <= '0;
          tx_q    <= 1'b0;
          state_q <= SEND;
        end
        SEND: if (baud_q != BAUD_LAST) begin
          baud_q <= baud_q + 1'b1;
        end else begin
          baud_q <= '0;
          if (bit_q != 4'd9) begin
            bit_q <= bit_q + 1'b1;
            tx_q  <= sh_q[0];
            sh_q  <= {1'b1, sh_q[8:1]};
          end else if (byte_q != 2'd2) begin
            bit_q  <= '0;
            byte_q <= byte_q + 1'b1;
            tx_q   <= 1'b0;
            sh_q   <= {1'b1, pix_q[15:8]};
            pix_q  <= {pix_q[7:0], 8'h00};
          end else begin
            state_q <= NEXT;
          end
        end
        NEXT: if (cnt_q == LAST_PIX) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else begin
          cnt_q   <= cnt_q + 1'b1;
          addr_q  <= cnt_q + 1'b1;
          rd_en_q <= 1'b1;
          state_q <= FETCH;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_rd_en  = rd_en_q;
  assign mem_addr   = addr_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign pixel_cnt  = cnt_q;
  assign frame_done = done_q;
endmodule
